// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icode values, the "no register" specifier and the fetch FSM states.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/y86_instr_len.sv
// Instruction format decode from the icode: length in bytes, register-byte presence and valC start byte.
// Purely combinational, no handshake; valc_off of 0 means the instruction carries no constant.
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    output logic [3:0] o_len,
    output logic       o_has_regs,
    output logic [3:0] o_valc_off,
    output logic       o_invalid
);

    always_comb begin
        o_len      = 4'd1;
        o_has_regs = 1'b0;
        o_valc_off = 4'd0;
        o_invalid  = 1'b0;
        case (i_icode)
            I_HALT, I_NOP, I_RET: begin
                o_len = 4'd1;
            end
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                o_len      = 4'd2;
                o_has_regs = 1'b1;
            end
            I_JXX, I_CALL: begin
                o_len      = 4'd9;
                o_valc_off = 4'd1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                o_len      = 4'd10;
                o_has_regs = 1'b1;
                o_valc_off = 4'd2;
            end
            default: begin
                o_invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Byte-serial Y86-64 instruction fetch: one memory read per byte, fields presented to decode via valid/ready.
// out_valid rises 2*len+1 cycles after start with 1-cycle memory; result held until out_ready.
module fetch_sequencer
    import y86_pkg::*;
#(
    parameter int IMEM_SIZE = 1024,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [63:0]   pc_in,
    output logic          imem_rd,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_rvalid,
    input  logic [7:0]    imem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    icode,
    output logic [3:0]    ifun,
    output logic [3:0]    rA,
    output logic [3:0]    rB,
    output logic [63:0]   valC,
    output logic [63:0]   valP,
    output logic          instr_invalid,
    output logic          imem_error,
    output logic          busy
);

    fetch_state_t  r_state;
    logic [63:0]   r_pc;
    logic [3:0]    r_byte_idx;
    logic [3:0]    r_len;
    logic [3:0]    r_valc_off;
    logic          r_has_regs;
    logic          r_oor;
    logic          r_imem_rd;
    logic [AW-1:0] r_imem_addr;
    logic [3:0]    r_icode;
    logic [3:0]    r_ifun;
    logic [3:0]    r_ra;
    logic [3:0]    r_rb;
    logic [63:0]   r_valc;
    logic [63:0]   r_valp;
    logic          r_invalid;
    logic          r_error;

    logic [3:0]    w_len;
    logic [3:0]    w_valc_off;
    logic          w_has_regs;
    logic          w_invalid;
    logic [3:0]    w_next_idx;
    logic [3:0]    w_cur_len;
    logic          w_last;
    logic [63:0]   w_fetch_addr;
    logic          w_oor;
    logic [2:0]    w_valc_k;

    y86_instr_len u_instr_len (
        .i_icode    (imem_rdata[7:4]),
        .o_len      (w_len),
        .o_has_regs (w_has_regs),
        .o_valc_off (w_valc_off),
        .o_invalid  (w_invalid)
    );

    // The read request is registered, so the address of the next byte is range-checked
    // on the edge that enters ISSUE rather than inside ISSUE itself.
    assign w_next_idx   = r_byte_idx + 4'd1;
    assign w_cur_len    = (r_byte_idx == 4'd0) ? w_len : r_len;
    assign w_last       = (w_next_idx == w_cur_len);
    assign w_fetch_addr = (r_state == S_IDLE) ? pc_in : (r_pc + {60'd0, w_next_idx});
    assign w_oor        = (w_fetch_addr >= 64'(IMEM_SIZE));
    assign w_valc_k     = 3'(r_byte_idx - r_valc_off);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pc        <= 64'd0;
            r_byte_idx  <= 4'd0;
            r_len       <= 4'd1;
            r_valc_off  <= 4'd0;
            r_has_regs  <= 1'b0;
            r_oor       <= 1'b0;
            r_imem_rd   <= 1'b0;
            r_imem_addr <= '0;
            r_icode     <= 4'd0;
            r_ifun      <= 4'd0;
            r_ra        <= RNONE;
            r_rb        <= RNONE;
            r_valc      <= 64'd0;
            r_valp      <= 64'd0;
            r_invalid   <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_imem_rd <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pc        <= pc_in;
                        r_byte_idx  <= 4'd0;
                        r_len       <= 4'd1;
                        r_valc_off  <= 4'd0;
                        r_has_regs  <= 1'b0;
                        r_icode     <= 4'd0;
                        r_ifun      <= 4'd0;
                        r_ra        <= RNONE;
                        r_rb        <= RNONE;
                        r_valc      <= 64'd0;
                        r_valp      <= 64'd0;
                        r_invalid   <= 1'b0;
                        r_error     <= 1'b0;
                        r_oor       <= w_oor;
                        r_imem_rd   <= !w_oor;
                        r_imem_addr <= w_fetch_addr[AW-1:0];
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_oor) begin
                        r_error <= 1'b1;
                        r_valp  <= r_pc;
                        r_state <= S_OUT;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_byte_idx == 4'd0) begin
                            r_icode    <= imem_rdata[7:4];
                            r_ifun     <= imem_rdata[3:0];
                            r_len      <= w_len;
                            r_has_regs <= w_has_regs;
                            r_valc_off <= w_valc_off;
                            r_invalid  <= w_invalid;
                        end
                        if (r_byte_idx == 4'd1 && r_has_regs) begin
                            r_ra <= imem_rdata[7:4];
                            r_rb <= imem_rdata[3:0];
                        end
                        if (r_valc_off != 4'd0 && r_byte_idx >= r_valc_off) begin
                            r_valc[{w_valc_k, 3'b000} +: 8] <= imem_rdata;
                        end
                        r_byte_idx <= w_next_idx;
                        if (w_last) begin
                            r_valp  <= r_pc + {60'd0, w_cur_len};
                            r_state <= S_OUT;
                        end else begin
                            r_oor       <= w_oor;
                            r_imem_rd   <= !w_oor;
                            r_imem_addr <= w_fetch_addr[AW-1:0];
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_rd       = r_imem_rd;
    assign imem_addr     = r_imem_addr;
    assign out_valid     = (r_state == S_OUT);
    assign busy          = (r_state != S_IDLE);
    assign icode         = r_icode;
    assign ifun          = r_ifun;
    assign rA            = r_ra;
    assign rB            = r_rb;
    assign valC          = r_valc;
    assign valP          = r_valp;
    assign instr_invalid = r_invalid;
    assign imem_error    = r_error;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: byte memory responder, instruction-level reference model, per-cycle compare.
module tb_fetch_sequencer;
    import y86_pkg::*;

    localparam int IMEM_SIZE = 1024;
    localparam int AW        = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [63:0]   pc_in;
    logic          imem_rd;
    logic [AW-1:0] imem_addr;
    logic          imem_rvalid;
    logic [7:0]    imem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    icode, ifun, rA, rB;
    logic [63:0]   valC, valP;
    logic          instr_invalid, imem_error, busy;

    always #5 clk = ~clk;

    fetch_sequencer #(.IMEM_SIZE(IMEM_SIZE), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .pc_in(pc_in),
        .imem_rd(imem_rd), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP),
        .instr_invalid(instr_invalid), .imem_error(imem_error), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Byte memory: response arrives lat cycles after the request (random 1..lat_max if lat_rand).
    logic [7:0]    mem [0:IMEM_SIZE-1];
    int            lat_max  = 1;
    bit            lat_rand = 1'b0;
    int            cnt      = 0;
    int            rd_count = 0;
    logic [AW-1:0] pend_addr = '0;
    logic [AW-1:0] exp_addr_q[$];

    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem[pend_addr];
            end
        end
        if (imem_rd) begin
            rd_count++;
            chk("outstanding_at_rd", 64'(cnt), 64'd0);
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read actual=addr %0d required=no read", imem_addr);
            end else begin
                chk("read_addr", 64'(imem_addr), 64'(exp_addr_q.pop_front()));
            end
            pend_addr = imem_addr;
            cnt       = lat_rand ? int'($urandom_range(1, lat_max)) : lat_max;
        end
    end

    // Reference model: what the fetched instruction must look like, straight from the Y86 formats.
    bit          exp_vld = 1'b0;
    logic [3:0]  e_icode, e_ifun, e_ra, e_rb;
    logic [63:0] e_valc, e_valp;
    logic        e_inv, e_err;
    int          e_nreads;

    task automatic model(input logic [63:0] pc);
        int         len, off, a;
        bit         regs;
        logic [7:0] b;
        e_icode = 4'h0; e_ifun = 4'h0; e_ra = 4'hF; e_rb = 4'hF;
        e_valc = 64'd0; e_inv = 1'b0; e_err = 1'b0; e_nreads = 0;
        exp_addr_q.delete();
        if (pc >= 64'(IMEM_SIZE)) begin
            e_err  = 1'b1;
            e_valp = pc;
            return;
        end
        b = mem[pc[AW-1:0]];
        len = 1; off = 0; regs = 1'b0;
        case (b[7:4])
            4'h0, 4'h1, 4'h9:       len = 1;
            4'h2, 4'h6, 4'hA, 4'hB: begin len = 2; regs = 1'b1; end
            4'h7, 4'h8:             begin len = 9; off = 1; end
            4'h3, 4'h4, 4'h5:       begin len = 10; off = 2; regs = 1'b1; end
            default:                e_inv = 1'b1;
        endcase
        e_icode = b[7:4];
        e_ifun  = b[3:0];
        for (int i = 0; i < len; i++) begin
            a = int'(pc) + i;
            if (a >= IMEM_SIZE) begin
                e_err = 1'b1;
                break;
            end
            b = mem[a];
            e_nreads++;
            exp_addr_q.push_back(AW'(a));
            if (i == 1 && regs) begin
                e_ra = b[7:4];
                e_rb = b[3:0];
            end
            if (off > 0 && i >= off) e_valc[8*(i-off) +: 8] = b;
        end
        e_valp = e_err ? pc : pc + 64'(len);
    endtask

    always @(negedge clk) begin
        if (exp_vld && out_valid) begin
            chk("icode", 64'(icode), 64'(e_icode));
            chk("ifun", 64'(ifun), 64'(e_ifun));
            chk("rA", 64'(rA), 64'(e_ra));
            chk("rB", 64'(rB), 64'(e_rb));
            chk("valC", valC, e_valc);
            chk("valP", valP, e_valp);
            chk("instr_invalid", 64'(instr_invalid), 64'(e_inv));
            chk("imem_error", 64'(imem_error), 64'(e_err));
            chk("busy_in_out", 64'(busy), 64'd1);
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_icode"}, 64'(icode), 64'd0);
        chk({tag, "_ifun"}, 64'(ifun), 64'd0);
        chk({tag, "_rA"}, 64'(rA), 64'hF);
        chk({tag, "_rB"}, 64'(rB), 64'hF);
        chk({tag, "_valC"}, valC, 64'd0);
        chk({tag, "_valP"}, valP, 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_imem_rd"}, 64'(imem_rd), 64'd0);
        chk({tag, "_instr_invalid"}, 64'(instr_invalid), 64'd0);
        chk({tag, "_imem_error"}, 64'(imem_error), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
    endtask

    // One full fetch; exp_lat > 0 also pins the start-to-out_valid cycle count.
    task automatic fetch(input logic [63:0] pc, input int lmax, input bit lrand,
                         input int hold, input int exp_lat);
        int n;
        lat_max  = lmax;
        lat_rand = lrand;
        rd_count = 0;
        model(pc);
        exp_vld = 1'b1;
        @(negedge clk);
        pc_in = pc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
        else if (exp_lat > 0) chk("out_valid_latency", 64'(n), 64'(exp_lat));
        for (int c = 0; c < hold; c++) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd0);
        chk("out_valid_after_accept", 64'(out_valid), 64'd0);
        chk("valP_persist", valP, e_valp);
        chk("read_count", 64'(rd_count), 64'(e_nreads));
        exp_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; pc_in = 64'd0;
        imem_rvalid = 1'b0; imem_rdata = 8'd0;
        for (int i = 0; i < IMEM_SIZE; i++) mem[i] = 8'h00;
        mem[0] = 8'h10;                                             // nop
        mem[5] = 8'hC0;                                             // invalid icode
        mem[20] = 8'h30; mem[21] = 8'hF3; mem[22] = 8'h0A;          // irmovq $10, %rbx
        mem[100] = 8'h80;                                           // call
        for (int k = 0; k < 8; k++) mem[101+k] = 8'(k + 1);
        mem[200] = 8'h60; mem[201] = 8'h23;                         // addq %rdx, %rbx
        mem[1020] = 8'h30; mem[1021] = 8'hF3; mem[1022] = 8'h0A; mem[1023] = 8'h00;

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("idle");

        fetch(64'd0, 1, 1'b0, 0, 3);
        chk("nop_valP", valP, 64'd1);

        fetch(64'd20, 1, 1'b0, 0, 21);
        chk("irmovq_rB", 64'(rB), 64'd3);
        chk("irmovq_valC", valC, 64'h0A);
        chk("irmovq_valP", valP, 64'd30);

        fetch(64'd100, 3, 1'b1, 0, 0);
        chk("call_valC", valC, 64'h0807060504030201);
        chk("call_valP", valP, 64'd109);

        fetch(64'd5, 1, 1'b0, 0, 3);
        chk("invalid_flag", 64'(instr_invalid), 64'd1);
        chk("invalid_valP", valP, 64'd6);
        chk("invalid_reads", 64'(rd_count), 64'd1);

        fetch(64'd1020, 1, 1'b0, 0, 10);
        chk("edge_error", 64'(imem_error), 64'd1);
        chk("edge_valP", valP, 64'd1020);
        chk("edge_reads", 64'(rd_count), 64'd4);

        fetch(64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0, 0, 2);
        chk("max_pc_error", 64'(imem_error), 64'd1);
        chk("max_pc_reads", 64'(rd_count), 64'd0);

        fetch(64'd200, 2, 1'b0, 5, 0);
        chk("opq_rA", 64'(rA), 64'd2);
        chk("opq_valP", valP, 64'd202);

        // Reset while waiting on a slow read; its late response must be ignored.
        lat_max  = 3;
        lat_rand = 1'b0;
        rd_count = 0;
        model(64'd20);
        @(negedge clk);
        pc_in = 64'd20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_addr_q.delete();
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals("mid_reset");
        repeat (5) @(negedge clk);
        check_reset_vals("after_stale");
        chk("reads_around_reset", 64'(rd_count), 64'd1);

        fetch(64'd0, 1, 1'b0, 0, 3);
        chk("recover_icode", 64'(icode), 64'd1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction fetch controller for the SEQ Y86-64 core. It reads one instruction at a time from the byte-wide instruction memory, one byte per read handshake. It determines the instruction length from the icode byte, assembles icode/ifun/rA/rB/valC/valP, and presents the result to decode through a valid/ready handshake. It sits between the PC-update logic, which supplies `pc_in` and `start`, and the byte-addressed instruction memory.

## Interface
- `IMEM_SIZE`, 1024: instruction memory depth in bytes; valid addresses are 0..IMEM_SIZE-1.
- `AW`, 10: instruction memory address width; must satisfy 2^AW >= IMEM_SIZE.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin fetch at `pc_in`; sampled only in IDLE.
- `pc_in` input 64: address of the instruction to fetch.
- `imem_rd` output 1: one-cycle read request pulse.
- `imem_addr` output AW: byte address accompanying `imem_rd`.
- `imem_rvalid` input 1: read data valid; arrives 1 or more cycles after `imem_rd`.
- `imem_rdata` input 8: read byte.
- `out_valid` output 1: fetched instruction fields are valid.
- `out_ready` input 1: decode accepts the instruction.
- `icode`, `ifun` output 4 each: instruction code and function.
- `rA`, `rB` output 4 each: register specifiers; 4'hF (RNONE) when there is no register byte.
- `valC` output 64: constant, little-endian assembled; 0 when absent.
- `valP` output 64: `pc_in` + instruction length, modulo 2^64.
- `instr_invalid` output 1: icode is greater than 4'hB.
- `imem_error` output 1: fetch address was out of range.
- `busy` output 1: state is not IDLE.

## Operation
- States:
  - IDLE: waits for `start`.
  - ISSUE: drives the read request.
  - WAIT: waits for read data.
  - OUT: presents the result.
- IDLE:
  - `start`=1: latch `pc_in` into `pc_q`, clear `byte_idx`, clear all fields (rA/rB to F), go to ISSUE.
  - `start` while not in IDLE: ignored.
- ISSUE:
  - Address check: if `pc_q + byte_idx >= IMEM_SIZE` (full 64-bit compare, no truncation), set `imem_error`, set `valP` = `pc_q`, go to OUT without issuing a read.
  - Otherwise: drive `imem_rd`=1 and `imem_addr` = low AW bits of `pc_q + byte_idx`, go to WAIT.
- WAIT, on `imem_rvalid`, capture `imem_rdata` by byte index:
  - byte 0: {icode, ifun}, and `len` from the length table.
  - byte 1 of cmovXX/irmovq/rmmovq/mrmovq/OPq/pushq/popq: {rA, rB}.
  - valC bytes fill `valC[8k+7:8k]` for k = 0..7. They start at byte 2 for irmovq/rmmovq/mrmovq and at byte 1 for jXX/call.
  - Then increment `byte_idx`. If `byte_idx+1 == len`, set `valP` = `pc_q + len` and go to OUT; else go to ISSUE.
- Length table:
  - 1 byte: halt, nop, ret.
  - 2 bytes: cmovXX, OPq, pushq, popq.
  - 9 bytes: jXX, call.
  - 10 bytes: irmovq, rmmovq, mrmovq.
  - icode > 4'hB: `instr_invalid`=1, len = 1.
- OUT: hold `out_valid`=1 and all fields stable until `out_ready`=1, then go to IDLE. Fields persist in IDLE until the next `start`.
- `imem_rvalid` outside WAIT is ignored. This covers stale responses after reset.
- halt is not special-cased: it is fetched as a normal 1-byte instruction, and stopping is the PC-update logic's job.

## Timing
- Reset: state IDLE. Outputs: `icode`=0, `ifun`=0, `rA`=F, `rB`=F, `valC`=0, `valP`=0. Flags `out_valid`, `imem_rd`, `instr_invalid`, `imem_error`, `busy` all 0; `imem_addr`=0.
- Reset mid-fetch: abandon immediately; no further `imem_rd` is issued.
- Per byte: 1 ISSUE cycle + at least 1 WAIT cycle. With 1-cycle memory latency, `out_valid` rises 2·len+1 cycles after the `start` cycle: 3 for nop, 21 for irmovq.
- `out_valid` and `out_ready` in the same cycle complete the handshake; `busy` falls the next cycle. A new `start` is accepted at the earliest in that IDLE cycle.
- At most one read is outstanding; `imem_rd` is never asserted in WAIT.
- `imem_error` and `instr_invalid` are both sticky until the next `start`. If both conditions occur, both are set.

## Structure
- Shared package `y86_pkg`:
  - icode constants `I_HALT` through `I_POPQ`.
  - `RNONE` = 4'hF.
  - fetch state enum.
- Sub-module `y86_instr_len`: combinational, icode in → `len[3:0]`, `has_regs`, `valc_off[3:0]`, `invalid` out. It is reused later by the PIPE fetch stage.

## Test plan
- nop (0x10) at PC 0, 1-cycle memory: `out_valid` at cycle 3; `icode`=1, `rA`=`rB`=F, `valC`=0, `valP`=1.
- irmovq 30 F3 0A 00 00 00 00 00 00 00 at PC 20: 10 `imem_rd` pulses at addresses 20..29; `rB`=3, `valC`=0x0A, `valP`=30.
- call 80 + 8 bytes 0x0102030405060708 little-endian at PC 100, with 3-cycle random memory latency: `valC`=0x0807060504030201, `valP`=109, no second read outstanding.
- Byte 0xC0 at PC 5: `instr_invalid`=1, `valP`=6, exactly one read.
- `pc_in`=1020 with irmovq: reads at 1020..1023, then `imem_error`=1, `valP`=1020, no read at 1024. Separately, `pc_in`=2^64-1 gives `imem_error` with no read.
- `out_ready` held low 5 cycles: fields stable. `reset` asserted during WAIT: IDLE next cycle, late `imem_rvalid` ignored, all outputs at reset values.
